// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
package tdm_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_e;
endpackage

// File: rtl/tdm_demux4_demux1x4.sv
// 2-bit select plus enable to a one-hot write-enable vector.
module demux1x4
  import tdm_pkg::*;
(
  input  logic [1:0]       sel_i,
  input  logic             en_i,
  output logic [LANES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux4.sv
// Collects four time-multiplexed words into one parallel frame
// with a one-deep output register and start-of-frame resync.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_d0,
  output logic [WIDTH-1:0] out_d1,
  output logic [WIDTH-1:0] out_d2,
  output logic [WIDTH-1:0] out_d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  slot_e            slot_q, slot_d;
  logic [WIDTH-1:0] stage_q [3];
  logic [WIDTH-1:0] out_q   [LANES];
  logic             ovld_q, ovld_d;
  logic             err_q;
  logic [7:0]       cnt_q;

  logic             accept;
  logic             restart;
  logic [1:0]       wsel;
  logic [LANES-1:0] we;
  logic             complete;

  assign in_ready = !(slot_q == SLOT3 && ovld_q && !out_ready);
  assign accept   = in_valid && in_ready;
  assign restart  = accept && in_sof && slot_q != SLOT0;

  // A mid-frame SOF word always lands in stage0.
  assign wsel     = restart ? 2'd0 : slot_q;
  assign complete = we[3];

  demux1x4 u_demux (
    .sel_i    (wsel),
    .en_i     (accept),
    .onehot_o (we)
  );

  always_comb begin
    slot_d = slot_q;
    if (restart) slot_d = SLOT1;
    else if (accept) slot_d = slot_e'(slot_q + 2'd1);
  end

  always_comb begin
    ovld_d = ovld_q;
    if (complete) ovld_d = 1'b1;
    else if (ovld_q && out_ready) ovld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= SLOT0;
      ovld_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      for (int i = 0; i < 3; i++) stage_q[i] <= '0;
      for (int i = 0; i < LANES; i++) out_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
      ovld_q <= ovld_d;
      err_q  <= restart;
      for (int i = 0; i < 3; i++)
        if (we[i]) stage_q[i] <= in_data;
      if (complete) begin
        out_q[0] <= stage_q[0];
        out_q[1] <= stage_q[1];
        out_q[2] <= stage_q[2];
        out_q[3] <= in_data;
        cnt_q    <= cnt_q + 8'd1;
      end
    end
  end

  assign out_d0    = out_q[0];
  assign out_d1    = out_q[1];
  assign out_d2    = out_q[2];
  assign out_d3    = out_q[3];
  assign out_valid = ovld_q;
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: WIDTH, 4, bit width of each data word and each output lane.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: in_data  input  WIDTH  time-multiplexed input word.
REQ-005 Port: in_valid  input  1  in_data valid this cycle.
REQ-006 Port: in_sof  input  1  start-of-frame marker, qualified by in_valid.
REQ-007 Port: in_ready  output  1  word accepted when in_valid && in_ready.
REQ-008 Port: out_d0, out_d1, out_d2, out_d3  output  WIDTH each  demultiplexed lanes for slots 0..3.
REQ-009 Port: out_valid  output  1  out_d0..out_d3 hold a complete frame.
REQ-010 Port: out_ready  input  1  consumer takes the frame when out_valid && out_ready.
REQ-011 Port: frame_err  output  1  one-cycle pulse when a partial frame is discarded.
REQ-012 Port: frame_cnt  output  8  count of frames delivered to the outputs.

Function
REQ-013 Slot FSM states SLOT0..SLOT3 (2-bit) SHALL advance SLOTn->SLOTn+1 per accepted word, with SLOT3 wrapping to SLOT0; the FSM SHALL hold when no word is accepted.
REQ-014 Words accepted in SLOT0..SLOT2 SHALL be written to staging registers stage0..stage2; no output SHALL change.
REQ-015 A word accepted in SLOT3 SHALL load out_d0..out_d3 with stage0, stage1, stage2 and in_data, and SHALL set out_valid on the next edge (latency 1 cycle from the 4th accepted word).
REQ-016 in_ready SHALL equal !(slot==SLOT3 && out_valid && !out_ready); it SHALL stay high in SLOT0..SLOT2.
REQ-017 out_valid SHALL stay high, with out_d0..out_d3 stable, until out_ready is sampled high.
REQ-018 If the current frame is taken and a new frame completes in the same cycle, out_valid SHALL stay high and the outputs SHALL show the new frame.
REQ-019 If the current frame is taken and no frame completes in that cycle, out_valid SHALL clear on the next edge.
REQ-020 An accepted word with in_sof=1 in SLOT0 SHALL be treated as a normal slot-0 word.
REQ-021 An accepted word with in_sof=0 in SLOT0 SHALL also be treated as a normal slot-0 word; in_sof is optional.
REQ-022 An accepted word with in_sof=1 in SLOT1..SLOT3 SHALL discard the partial frame, pulse frame_err for one cycle, store the word as stage0, and move the FSM to SLOT1.
REQ-023 A word discarded under REQ-022 SHALL NOT update out_d0..out_d3, out_valid or frame_cnt.
REQ-024 in_sof and in_data SHALL be ignored when in_valid=0 or in_ready=0.
REQ-025 frame_cnt SHALL increment by 1 on each out_d0..out_d3 load and SHALL wrap 255->0.

Reset
REQ-026 While rst_n=0, all of the following SHALL be held immediately, independent of clk: slot=SLOT0, stage0..stage2=0, out_d0..out_d3=0, out_valid=0, frame_err=0, frame_cnt=0.
REQ-027 While rst_n=0, in_ready SHALL be 1, as a consequence of REQ-016.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame and any pending output frame, with no frame_err pulse.
REQ-029 The first word accepted after reset release SHALL be slot 0.

Structure
REQ-030 Shared package tdm_pkg SHALL hold the WIDTH default, the constant LANES=4, and the slot-state type SLOT0..SLOT3.
REQ-031 Slot-to-stage write enables SHALL come from one combinational sub-module demux1x4: a 2-bit select plus an enable in, a 4-bit one-hot enable out.

Verification
REQ-032 Reset, then words 1,2,3,4 on consecutive cycles with out_ready=1 -> out_d0..3=1,2,3,4; out_valid high one cycle after word 4; frame_cnt=1.
REQ-033 Two frames A..D then E..H with out_ready=0 -> in_ready low in SLOT3 holding H; raising out_ready delivers A..D, then E..H on the next cycle with out_valid held high.
REQ-034 Words 5,6 then 9 with in_sof=1, then 10,11,12 -> frame_err pulse at the 9 edge; output frame 9,10,11,12; frame_cnt=1.
REQ-035 rst_n asserted low after 2 words and released between clock edges -> outputs zero immediately; next 4 words form slot 0..3 of a fresh frame.
REQ-036 Drive 256 complete frames -> frame_cnt wraps to 0; in_valid toggling with gaps changes no result.
